baud_tick_gen_prog: RTL and testbench

Runtime-programmable fractional baud tick generator. It produces an oversampling tick, a bit tick and a mid-bit tick from one phase accumulator. Rate changes take effect only on bit boundaries, and a resync input restarts the phase. It sits between the CPU/SPI register file and the UART TX/RX engines, where it replaces fixed-rate, compile-time tick generation.

---
 rtl/baud_tick_gen_prog.sv | 89 ++++++++
 tb/tb_baud_tick_gen_prog.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/baud_tick_gen_prog.sv
// Programmable fractional baud tick generator: os/bit/mid ticks from one phase accumulator.
// Define BAUD_MID_TICK_EN to build the mid-bit tick; otherwise mid_tick is tied low.
module baud_tick_gen_prog #(
   parameter int unsigned ACC_WIDTH  = 16,
   parameter int unsigned OVERSAMPLE = 8,
   parameter int unsigned INC_RESET  = 1208
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   input  logic                 resync,
   input  logic                 inc_wr,
   input  logic [ACC_WIDTH-1:0] inc_data,
   output logic                 inc_pending,
   output logic [ACC_WIDTH-1:0] inc_active,
   output logic                 os_tick,
   output logic                 bit_tick,
   output logic                 mid_tick
);

   localparam int unsigned      CW      = $clog2(OVERSAMPLE);
   localparam logic [CW-1:0]    OS_LAST = CW'(OVERSAMPLE - 1);

   logic [ACC_WIDTH-1:0] acc;
   logic [ACC_WIDTH-1:0] shadow;
   logic [CW-1:0]        os_cnt;
   logic [ACC_WIDTH:0]   sum;
   logic                 carry;
   logic                 last;
   logic                 run;
   logic                 apply;

   // Rate swaps only at a bit boundary, or whenever the phase is being cleared anyway.
   always_comb begin
      sum   = {1'b0, acc} + {1'b0, inc_active};
      carry = sum[ACC_WIDTH];
      last  = (os_cnt == OS_LAST);
      run   = enable && !resync;
      apply = !run || (carry && last);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc         <= '0;
         os_cnt      <= '0;
         os_tick     <= 1'b0;
         bit_tick    <= 1'b0;
         inc_active  <= ACC_WIDTH'(INC_RESET);
         shadow      <= ACC_WIDTH'(INC_RESET);
         inc_pending <= 1'b0;
      end else begin
         if (run) begin
            acc      <= sum[ACC_WIDTH-1:0];
            os_tick  <= carry;
            bit_tick <= carry && last;
            if (carry)
               os_cnt <= last ? '0 : os_cnt + 1'b1;
         end else begin
            acc      <= '0;
            os_cnt   <= '0;
            os_tick  <= 1'b0;
            bit_tick <= 1'b0;
         end
         if (apply && inc_pending) begin
            inc_active  <= shadow;
            inc_pending <= 1'b0;
         end
         // A write on the apply edge lands after the old shadow moves over, so it stays pending.
         if (inc_wr) begin
            shadow      <= inc_data;
            inc_pending <= 1'b1;
         end
      end
   end

`ifdef BAUD_MID_TICK_EN
   localparam logic [CW-1:0] OS_MID = CW'(OVERSAMPLE / 2 - 1);

   always_ff @(posedge clk) begin
      if (rst)
         mid_tick <= 1'b0;
      else
         mid_tick <= run && carry && (os_cnt == OS_MID);
   end
`else
   assign mid_tick = 1'b0;
`endif

endmodule

// File: tb/tb_baud_tick_gen_prog.sv
// Directed bench for baud_tick_gen_prog at ACC_WIDTH=8, OVERSAMPLE=4, INC_RESET=64.
// Each scenario is a per-edge plan of inputs and hand-derived expected outputs.
module tb_baud_tick_gen_prog;

   localparam int unsigned NE = 160;
`ifdef BAUD_MID_TICK_EN
   localparam bit MID_EN = 1'b1;
`else
   localparam bit MID_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       enable = 1'b0;
   logic       resync = 1'b0;
   logic       inc_wr = 1'b0;
   logic [7:0] inc_data = '0;
   logic       inc_pending;
   logic [7:0] inc_active;
   logic       os_tick;
   logic       bit_tick;
   logic       mid_tick;

   int total = 0;
   int bad   = 0;

   logic       en_v   [0:NE-1];
   logic       wr_v   [0:NE-1];
   logic       rs_v   [0:NE-1];
   logic [7:0] wr_d   [0:NE-1];
   logic       x_os   [0:NE-1];
   logic       x_bit  [0:NE-1];
   logic       x_mid  [0:NE-1];
   logic       x_pend [0:NE-1];
   logic [7:0] x_act  [0:NE-1];

   baud_tick_gen_prog #(
      .ACC_WIDTH (8),
      .OVERSAMPLE(4),
      .INC_RESET (64)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .resync     (resync),
      .inc_wr     (inc_wr),
      .inc_data   (inc_data),
      .inc_pending(inc_pending),
      .inc_active (inc_active),
      .os_tick    (os_tick),
      .bit_tick   (bit_tick),
      .mid_tick   (mid_tick)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   task automatic clear_plan();
      for (int unsigned e = 0; e < NE; e++) begin
         en_v[e]   = 1'b1;
         wr_v[e]   = 1'b0;
         rs_v[e]   = 1'b0;
         wr_d[e]   = '0;
         x_os[e]   = 1'b0;
         x_bit[e]  = 1'b0;
         x_mid[e]  = 1'b0;
         x_pend[e] = 1'b0;
         x_act[e]  = 8'd64;
      end
   endtask

   task automatic do_reset(input string name);
      rst = 1'b1; enable = 1'b0; resync = 1'b0; inc_wr = 1'b0; inc_data = '0;
      @(posedge clk); #1;
      check_val({name, "/rst_os"},   32'(os_tick),     32'd0);
      check_val({name, "/rst_bit"},  32'(bit_tick),    32'd0);
      check_val({name, "/rst_mid"},  32'(mid_tick),    32'd0);
      check_val({name, "/rst_pend"}, 32'(inc_pending), 32'd0);
      check_val({name, "/rst_act"},  32'(inc_active),  32'd64);
      rst = 1'b0;
   endtask

   task automatic run_plan(input string name, input int unsigned n);
      for (int unsigned e = 1; e <= n; e++) begin
         enable   = en_v[e];
         inc_wr   = wr_v[e];
         inc_data = wr_d[e];
         resync   = rs_v[e];
         @(posedge clk); #1;
         check_val($sformatf("%s/e%0d_os", name, e),   32'(os_tick),     32'(x_os[e]));
         check_val($sformatf("%s/e%0d_bit", name, e),  32'(bit_tick),    32'(x_bit[e]));
         check_val($sformatf("%s/e%0d_mid", name, e),  32'(mid_tick),    32'(x_mid[e] & MID_EN));
         check_val($sformatf("%s/e%0d_pend", name, e), 32'(inc_pending), 32'(x_pend[e]));
         check_val($sformatf("%s/e%0d_act", name, e),  32'(inc_active),  32'(x_act[e]));
      end
      inc_wr = 1'b0;
      resync = 1'b0;
   endtask

   initial begin
      // Baseline: inc=64 -> os every 4 edges, mid at 8, bit every 16.
      clear_plan();
      for (int unsigned e = 1; e <= 32; e++) begin
         x_os[e]  = (e % 4 == 0);
         x_bit[e] = (e % 16 == 0);
         x_mid[e] = (e % 16 == 8);
      end
      do_reset("base");
      run_plan("base", 32);

      // Write 128 at edge 6: pending until bit_tick at 16, then os every 2 edges.
      clear_plan();
      for (int unsigned e = 1; e <= 16; e++) x_os[e] = (e % 4 == 0);
      for (int unsigned e = 17; e <= 32; e++) x_os[e] = (e % 2 == 0);
      x_bit[16] = 1'b1; x_bit[24] = 1'b1; x_bit[32] = 1'b1;
      x_mid[8]  = 1'b1; x_mid[20] = 1'b1; x_mid[28] = 1'b1;
      wr_v[6] = 1'b1; wr_d[6] = 8'd128;
      for (int unsigned e = 6; e <= 15; e++) x_pend[e] = 1'b1;
      for (int unsigned e = 16; e <= 32; e++) x_act[e] = 8'd128;
      do_reset("rate");
      run_plan("rate", 32);

      // Resync at edge 10 restarts the phase: os at 14,18,..; bit at 26.
      clear_plan();
      rs_v[10] = 1'b1;
      x_os[4] = 1'b1; x_os[8] = 1'b1; x_os[14] = 1'b1; x_os[18] = 1'b1;
      x_os[22] = 1'b1; x_os[26] = 1'b1; x_os[30] = 1'b1;
      x_bit[26] = 1'b1;
      x_mid[8] = 1'b1; x_mid[18] = 1'b1;
      do_reset("resync");
      run_plan("resync", 32);

      // Stopped rate, then 255 written while disabled (coincident write stays pending).
      clear_plan();
      wr_v[2] = 1'b1; wr_d[2] = 8'd0;
      en_v[3] = 1'b0;
      x_pend[2] = 1'b1;
      for (int unsigned e = 3; e <= 104; e++) x_act[e] = 8'd0;
      en_v[104] = 1'b0; en_v[105] = 1'b0;
      wr_v[104] = 1'b1; wr_d[104] = 8'd255;
      x_pend[104] = 1'b1;
      for (int unsigned e = 105; e <= 125; e++) x_act[e] = 8'd255;
      for (int unsigned e = 107; e <= 125; e++) begin
         x_os[e]  = 1'b1;
         x_bit[e] = (e >= 110) && ((e - 110) % 4 == 0);
         x_mid[e] = (e >= 108) && ((e - 108) % 4 == 0);
      end
      do_reset("stop");
      run_plan("stop", 125);

      // Write on the bit_tick edge (16): old rate held to 32, new rate after.
      clear_plan();
      wr_v[16] = 1'b1; wr_d[16] = 8'd128;
      for (int unsigned e = 1; e <= 32; e++) x_os[e] = (e % 4 == 0);
      x_os[34] = 1'b1; x_os[36] = 1'b1; x_os[38] = 1'b1; x_os[40] = 1'b1;
      x_bit[16] = 1'b1; x_bit[32] = 1'b1; x_bit[40] = 1'b1;
      x_mid[8] = 1'b1; x_mid[24] = 1'b1; x_mid[36] = 1'b1;
      for (int unsigned e = 16; e <= 31; e++) x_pend[e] = 1'b1;
      for (int unsigned e = 32; e <= 40; e++) x_act[e] = 8'd128;
      do_reset("coinc");
      run_plan("coinc", 40);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
